// File: rtl/dino_score_pkg.sv
// ----------------------------------------------------------------------------
// dino_score_pkg
// Shared types and constants for the dino runner score engine.
//   score_state_t : game-phase state encoding (IDLE, RUN, OVER)
//   DEF_*         : default parameter values used by the score engine
//   sat_value()   : saturation value of a score register for a given width
//                   and encoding (all ones for binary, all nines for BCD)
// ----------------------------------------------------------------------------
package dino_score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } score_state_t;

    localparam int DEF_SCORE_W         = 16;
    localparam int DEF_TICKS_PER_POINT = 6;
    localparam int DEF_MILESTONE       = 100;

    // Largest representable score: binary all ones, or packed BCD 4'h9 in
    // every nibble (bits 0 and 3 of each nibble set).
    function automatic logic [63:0] sat_value(input int width, input bit bcd);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                v[i] = bcd ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/dino_bcd_inc.sv
// ----------------------------------------------------------------------------
// dino_bcd_inc
// Combinational packed-BCD incrementer with full carry ripple.
// Ports:
//   value     in  SCORE_W : packed BCD operand (SCORE_W/4 digits)
//   sum       out SCORE_W : value + 1 in packed BCD (wraps to 0 when all nines)
//   all_nines out 1       : every digit of value is 9 (saturation flag)
// ----------------------------------------------------------------------------
module dino_bcd_inc
    import dino_score_pkg::*;
#(
    parameter int SCORE_W = DEF_SCORE_W
) (
    input  logic [SCORE_W-1:0] value,
    output logic [SCORE_W-1:0] sum,
    output logic               all_nines
);

    localparam int DIGITS = SCORE_W / 4;

    always_comb begin
        logic carry;
        // NOTE: every output gets a default before any conditional update,
        // so no path leaves a value unassigned and no latch is inferred.
        sum       = value;
        all_nines = 1'b1;
        carry     = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (value[4*d +: 4] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (value[4*d +: 4] == 4'd9) begin
                    sum[4*d +: 4] = 4'd0;
                end else begin
                    sum[4*d +: 4] = value[4*d +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dino_score_tracker.sv
// ----------------------------------------------------------------------------
// dino_score_tracker
// Score engine for the dino runner: converts start/over/frame-tick pulses
// into a saturating binary or packed-BCD score, a saturating difficulty
// level with one-cycle milestone pulses, and an optional high score.
// Optional feature macro: DINO_SCORE_HISCORE_EN (high-score register and
// comparator; when undefined hiscore/new_hiscore are tied to 0).
// Ports:
//   clk         in  1       : clock
//   rst         in  1       : synchronous active-high full reset
//   game_start  in  1       : pulse, starts a game from IDLE/OVER
//   game_over   in  1       : pulse, ends a game (priority over start)
//   game_tick   in  1       : end-of-frame pulse
//   score       out SCORE_W : current score (binary or packed BCD)
//   running     out 1       : high while in RUN
//   milestone   out 1       : one-cycle pulse per MILESTONE points
//   level       out LEVEL_W : difficulty level, saturating
//   hiscore     out SCORE_W : best finished-game score
//   new_hiscore out 1       : last finished game set a new best
// ----------------------------------------------------------------------------
module dino_score_tracker
    import dino_score_pkg::*;
#(
    parameter int SCORE_W         = DEF_SCORE_W,
    parameter int BCD             = 0,
    parameter int TICKS_PER_POINT = DEF_TICKS_PER_POINT,
    parameter int MILESTONE       = DEF_MILESTONE,
    parameter int LEVEL_W         = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_start,
    input  logic               game_over,
    input  logic               game_tick,
    output logic [SCORE_W-1:0] score,
    output logic               running,
    output logic               milestone,
    output logic [LEVEL_W-1:0] level,
    output logic [SCORE_W-1:0] hiscore,
    output logic               new_hiscore
);

    // Counters need at least one bit even when the divide ratio is 1.
    localparam int TCNT_W = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
    localparam int MCNT_W = (MILESTONE > 1) ? $clog2(MILESTONE) : 1;

    localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(TICKS_PER_POINT - 1);
    localparam logic [MCNT_W-1:0]  MCNT_LAST = MCNT_W'(MILESTONE - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};

    score_state_t       state;
    logic [TCNT_W-1:0]  tcnt;
    logic [MCNT_W-1:0]  mcnt;
    logic [SCORE_W-1:0] inc_sum;
    logic               at_sat;

    // Incremented score and saturation flag for the selected encoding.
    generate
        if (BCD != 0) begin : g_bcd
            dino_bcd_inc #(
                .SCORE_W (SCORE_W)
            ) u_bcd_inc (
                .value     (score),
                .sum       (inc_sum),
                .all_nines (at_sat)
            );
        end else begin : g_bin
            localparam logic [SCORE_W-1:0] SAT = SCORE_W'(sat_value(SCORE_W, 1'b0));
            assign inc_sum = score + SCORE_W'(1);
            assign at_sat  = (score == SAT);
        end
    endgenerate

`ifdef DINO_SCORE_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q;
    logic               new_hiscore_q;
    assign hiscore     = hiscore_q;
    assign new_hiscore = new_hiscore_q;
`else
    assign hiscore     = '0;
    assign new_hiscore = 1'b0;
`endif

    // NOTE: all state here is sequential, so every assignment is
    // non-blocking; that keeps each register reading the pre-edge value of
    // its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            score     <= '0;
            running   <= 1'b0;
            milestone <= 1'b0;
            level     <= '0;
            tcnt      <= '0;
            mcnt      <= '0;
`ifdef DINO_SCORE_HISCORE_EN
            hiscore_q     <= '0;
            new_hiscore_q <= 1'b0;
`endif
        end else begin
            milestone <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    // game_over wins over a coincident game_start.
                    if (game_start && !game_over) begin
                        state   <= RUN;
                        running <= 1'b1;
                        score   <= '0;
                        tcnt    <= '0;
                        mcnt    <= '0;
                        level   <= '0;
`ifdef DINO_SCORE_HISCORE_EN
                        new_hiscore_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (game_over) begin
                        // A tick arriving with game_over is dropped.
                        state   <= OVER;
                        running <= 1'b0;
`ifdef DINO_SCORE_HISCORE_EN
                        // Packed BCD orders correctly as an unsigned number.
                        if (score > hiscore_q) begin
                            hiscore_q     <= score;
                            new_hiscore_q <= 1'b1;
                        end
`endif
                    end else if (game_tick) begin
                        if (tcnt == TCNT_LAST) begin
                            tcnt <= '0;
                            // Once saturated, points are discarded and the
                            // milestone counter freezes with the score.
                            if (!at_sat) begin
                                score <= inc_sum;
                                if (mcnt == MCNT_LAST) begin
                                    mcnt      <= '0;
                                    milestone <= 1'b1;
                                    if (level != LEVEL_MAX) begin
                                        level <= level + LEVEL_W'(1);
                                    end
                                end else begin
                                    mcnt <= mcnt + MCNT_W'(1);
                                end
                            end
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    score   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/dino_score_tracker.md
# dino_score_tracker

Parametrised score engine for the dino runner, replacing the fixed 16-bit score counter. It turns start/over/frame-tick pulses from the game logic into a saturating binary or BCD score, a difficulty level with milestone pulses for the speed-up and blink effects, and an optional high-score register. It sits between the game FSM and the display/pin mux in the top-level wrapper.

## Interface
- `SCORE_W`, 16: score width in bits. Must be a multiple of 4 when `BCD`=1.
- `BCD`, 0: 0 gives a binary score; 1 gives packed BCD with `SCORE_W/4` digits.
- `TICKS_PER_POINT`, 6: number of frame ticks per point. Must be ≥1.
- `MILESTONE`, 100: number of points per milestone/level step. Must be ≥1.
- `LEVEL_W`, 3: width of the level output.

- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `game_start`  in  1: one-cycle pulse that starts a game.
- `game_over`  in  1: one-cycle pulse that ends a game.
- `game_tick`  in  1: one-cycle end-of-frame pulse at 60 Hz.
- `score`  out  SCORE_W: current score.
- `running`  out  1: high while in RUN.
- `milestone`  out  1: one-cycle pulse when the score crosses a milestone.
- `level`  out  LEVEL_W: difficulty level, saturating.
- `hiscore`  out  SCORE_W: best score (gated by the macro).
- `new_hiscore`  out  1: last finished game set a new best (gated by the macro).

## Operation
- The FSM has three states: IDLE, RUN and OVER. Reset enters IDLE.
- IDLE/OVER → RUN:
  - Trigger: `game_start` && !`game_over`.
  - Clears `score`, the tick prescaler, the milestone counter, `level` and `new_hiscore`.
- RUN → OVER on `game_over`.
- `game_over` has priority in every state. With both pulses in IDLE/OVER, the state is unchanged.
- `game_start` while in RUN is ignored. There is no restart mid-game.
- Prescaler `tcnt` counts 0..TICKS_PER_POINT-1 and advances only on `game_tick` in RUN. On a tick with `tcnt`==TICKS_PER_POINT-1:
  - `tcnt` returns to 0.
  - One point is awarded.
- Point award:
  - Binary mode: `score`+1.
  - BCD mode: digit-wise increment with carry ripple across all digits.
- Score saturation:
  - Binary saturates at all-ones; BCD saturates at all digits 9.
  - At saturation no further increments occur. The prescaler keeps running, but points are discarded and neither milestone nor level advances.
- `mcnt` counts awarded points 0..MILESTONE-1, independent of score encoding. On wrap:
  - `milestone` pulses.
  - `level` increments, saturating at 2^LEVEL_W−1.
- A `game_tick` in the same cycle as `game_over` is not counted.
- In OVER, `score` holds its final value until the next start. In IDLE, `score` is 0.
- `running` = (state==RUN).

## Timing
- All outputs are registered.
- Reset values: `score`=0, `running`=0, `milestone`=0, `level`=0, `hiscore`=0, `new_hiscore`=0, state=IDLE, `tcnt`=0, `mcnt`=0.
- Reset mid-game returns to IDLE on the next edge, but `hiscore` is also cleared (rst is a full reset).
- Latency:
  - `score`, `level` and `milestone` update on the edge after the sampled `game_tick`, i.e. one-cycle latency.
  - `running` rises the cycle after `game_start` and falls the cycle after `game_over`.
- `milestone` is high for exactly one cycle per crossing.
- Inputs are sampled every cycle and are assumed to be synchronous single-cycle pulses. There is no edge detection.

## Configuration
- Macro `DINO_SCORE_HISCORE_EN`.
- Defined:
  - On the RUN→OVER edge, if `score` > `hiscore`: `hiscore` ← `score` and `new_hiscore` ← 1.
  - The comparison is unsigned; for BCD, packed BCD compares correctly as unsigned.
  - `hiscore` survives game restarts and is cleared only by `rst`.
- Undefined: the register and comparator are removed, and `hiscore` and `new_hiscore` are tied to 0.

## Structure
- Package `dino_score_pkg` holds:
  - the state enum `score_state_t` {IDLE, RUN, OVER};
  - the default constants (`SCORE_W`, `TICKS_PER_POINT`, `MILESTONE`);
  - a function returning the saturation value for a given width and mode.
- Sub-module `dino_bcd_inc`: a combinational packed-BCD incrementer. Input is `SCORE_W` bits; outputs are sum and all-nines. It is instantiated only when `BCD`=1 (generate).

## Test plan
- **Basic count** (defaults, binary): rst, start, 60 ticks → `score`=10, `level`=0, `running`=1. Then `game_over` → `running`=0 next cycle and `score` holds 10 through 5 further ticks.
- **Milestone** (`TICKS_PER_POINT`=1, `MILESTONE`=4): 9 ticks → `milestone` pulses after ticks 4 and 8, each one cycle wide, and `level`=2.
- **BCD carry** (`BCD`=1, `SCORE_W`=8, `TICKS_PER_POINT`=1): 19 ticks → `score`=8'h19; 1 more tick → 8'h20.
- **Saturation** (`SCORE_W`=4, `TICKS_PER_POINT`=1):
  - Binary: 20 ticks → `score`=4'hF.
  - `BCD`=1: 20 ticks → `score`=4'h9, and no milestone after saturation.
- **Simultaneous events**:
  - start+over in IDLE → remains IDLE.
  - tick+over on the final prescaler tick → `score` unchanged.
  - start during RUN → `score` not cleared.
- **High score** (macro defined): game 1 ends at 10 → `hiscore`=10, `new_hiscore`=1. Game 2 ends at 7 → `hiscore`=10, `new_hiscore`=0. `rst` → `hiscore`=0. Without the macro, `hiscore` stays 0 throughout.
